axi_burst_to_iob: RTL and testbench
===================================

Name: axi_burst_to_iob

Overview:
- AXI4 slave responder that terminates one AXI4 master port, such as the system's memory port behind the interconnect.
- Converts each AXI burst into a sequence of single-word native transactions (valid/addr/wdata/wstrb in, rdata/ready back).
- Lets native-interface memories and peripherals act as AXI targets in simulation and on FPGA.
- One outstanding transaction at a time; reads and writes are serialized.

Parameters:
ADDR_W, 24, AXI and native byte-address width
DATA_W, 32, data width; DATA_W/8 byte lanes
ID_W, 1, AXI ID width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
s_axi_awid  in  ID_W  write ID
s_axi_awaddr  in  ADDR_W  write start address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  log2 bytes per beat
s_axi_awburst  in  2  burst type
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_bid  out  ID_W  response ID
s_axi_bresp  out  2  write response
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  as AW  read address channel
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_rid  out  ID_W  read ID
s_axi_rdata  out  DATA_W  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid/s_axi_rready  out/in  1  R handshake
valid  out  1  native request
addr  out  ADDR_W  native byte address, word aligned
wdata  out  DATA_W  native write data
wstrb  out  DATA_W/8  native byte enables; 0 means read
rdata  in  DATA_W  native read data, sampled when ready=1
ready  in  1  native completion

Behaviour:
- Reset values: all AXI ready/valid outputs 0, bresp/rresp 0, rdata 0, rlast 0, bid/rid 0, valid 0, addr/wdata/wstrb 0, internal priority = write.
- Reset asserted mid-burst: the burst is discarded. No B or R is issued for it afterwards.
- FSM states: IDLE, WR_DATA, WR_MEM, WR_RESP, RD_MEM, RD_DATA.
- IDLE:
  - awready = awvalid & (~arvalid | prio==write).
  - arready = arvalid & (~awvalid | prio==read).
  - When both are valid, the priority bit is used and then toggled, so grants alternate.
  - On an AW handshake: capture id, addr, len, size, burst; clear the error flag; go to WR_DATA.
  - On an AR handshake: capture the same fields; go to RD_MEM.
- WR_DATA: wready=1. On a W handshake, capture wdata/wstrb, go to WR_MEM, and assert valid in the next cycle.
- WR_MEM: valid held with stable addr/wdata/wstrb until ready=1. Then valid=0 in the next cycle.
  - Last beat (count==len): go to WR_RESP.
  - Otherwise: advance the address and return to WR_DATA.
- WR_RESP: bvalid=1 and bid=captured id, held until bready; then go to IDLE.
- RD_MEM: valid=1 with wstrb=0. When ready=1, capture rdata and go to RD_DATA.
- RD_DATA: rvalid=1, rlast = (count==len). Held stable until rready.
  - Last beat: go to IDLE.
  - Otherwise: advance the address and return to RD_MEM.
- Address generation:
  - addr output = current address with the low log2(DATA_W/8) bits forced to 0.
  - FIXED (00): address is unchanged between beats.
  - INCR (01): next = current + (1<<size), wrapping modulo 2^ADDR_W.
  - No 4 KB boundary check.
- Error cases: WRAP (10), reserved (11), or size > log2(DATA_W/8).
  - The burst still runs all len+1 beats on AXI, but no native access is issued (WR_MEM and RD_MEM are skipped).
  - bresp = 2'b10, rresp = 2'b10, rdata = 0.
- wlast mismatch: wlast=1 before the final beat, or wlast=0 on the final beat, sets bresp = 2'b10.
  - Beat count is always taken from awlen.
  - The native writes are still performed.
- Normal completion gives bresp/rresp = 2'b00.
- Beat counter is 8 bits, so up to 256-beat bursts are supported.
- Minimum latency:
  - Write: AW handshake cycle N; W handshake at N+1; valid at N+2; with ready at N+2, bvalid at N+3.
  - Read: AR handshake at N; valid at N+1; with ready at N+1, rvalid at N+2.

Decomposition:
- Package axi_burst_to_iob_pkg holds:
  - state enum (6 states);
  - burst constants FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - response constants OKAY=2'b00, SLVERR=2'b10.
- Sub-module axi_burst_addr_gen (combinational next-address plus error-detect from addr/size/burst) is natural and is reused by both channels.

Test Plan:
- Single write: awaddr=0x100, awlen=0, awsize=2, INCR, wdata=0xDEADBEEF, wstrb=F, ready one cycle after valid -> one native write at addr 0x100 with the same data/strb; bresp=00; bid echoes awid.
- INCR read: araddr=0x200, arlen=3, size=2, native memory returns addr-based data -> native addrs 0x200, 0x204, 0x208, 0x20C; 4 R beats; rlast only on the 4th; rresp=00.
- FIXED write: awlen=2, awaddr=0x40 -> three native writes, all at 0x40, with the beat data in order.
- Simultaneous AW and AR in IDLE, twice back-to-back -> write granted first, read second (alternation); no overlap of native accesses.
- WRAP read, arlen=1 -> no native valid; 2 beats with rresp=10, rdata=0, rlast on beat 2. Write burst with wlast asserted on beat 1 of 3 -> 3 native writes, bresp=10.
- Backpressure and reset:
  - rready low 5 cycles and ready delayed 3 cycles -> rdata/rlast/valid/addr held stable throughout.
  - rst_n pulsed low during beat 2 of an 8-beat read -> all outputs return to reset values immediately; the next AR is serviced normally.

Source files
------------

// File: rtl/axi_burst_to_iob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_to_iob_pkg
// Description : Shared types and constants for the AXI-burst to native bridge
// Revision    : 1.0 - initial release
// ============================================================================
package axi_burst_to_iob_pkg;

   // Controller states; one outstanding transaction at a time
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_DATA = 3'd1,
      ST_WR_MEM  = 3'd2,
      ST_WR_RESP = 3'd3,
      ST_RD_MEM  = 3'd4,
      ST_RD_DATA = 3'd5
   } state_t;

   // AXI burst types
   localparam logic [1:0] FIXED  = 2'b00;
   localparam logic [1:0] INCR   = 2'b01;
   localparam logic [1:0] WRAP   = 2'b10;

   // AXI response codes
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_burst_to_iob_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_to_iob_if
// Description : AXI4 slave port plus native single-word request port
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_burst_to_iob_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32,
   parameter int ID_W   = 1
);
   // AXI write address / data / response
   logic [ID_W-1:0]     s_axi_awid;
   logic [ADDR_W-1:0]   s_axi_awaddr;
   logic [7:0]          s_axi_awlen;
   logic [2:0]          s_axi_awsize;
   logic [1:0]          s_axi_awburst;
   logic                s_axi_awvalid;
   logic                s_axi_awready;
   logic [DATA_W-1:0]   s_axi_wdata;
   logic [DATA_W/8-1:0] s_axi_wstrb;
   logic                s_axi_wlast;
   logic                s_axi_wvalid;
   logic                s_axi_wready;
   logic [ID_W-1:0]     s_axi_bid;
   logic [1:0]          s_axi_bresp;
   logic                s_axi_bvalid;
   logic                s_axi_bready;
   // AXI read address / data
   logic [ID_W-1:0]     s_axi_arid;
   logic [ADDR_W-1:0]   s_axi_araddr;
   logic [7:0]          s_axi_arlen;
   logic [2:0]          s_axi_arsize;
   logic [1:0]          s_axi_arburst;
   logic                s_axi_arvalid;
   logic                s_axi_arready;
   logic [ID_W-1:0]     s_axi_rid;
   logic [DATA_W-1:0]   s_axi_rdata;
   logic [1:0]          s_axi_rresp;
   logic                s_axi_rlast;
   logic                s_axi_rvalid;
   logic                s_axi_rready;
   // Native request port
   logic                valid;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic [DATA_W-1:0]   rdata;
   logic                ready;

   // Bridge side: terminates AXI, drives native requests
   modport slave (
      input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bid, s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      input  s_axi_rready,
      output valid, addr, wdata, wstrb,
      input  rdata, ready
   );

   // Environment side: AXI master and native memory
   modport master (
      output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      output s_axi_rready,
      input  valid, addr, wdata, wstrb,
      output rdata, ready
   );
endinterface
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Next-beat address and unsupported-burst detection
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
   import axi_burst_to_iob_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        size,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr,
   output logic              err
);
   localparam int LG_BYTES = $clog2(DATA_W/8);

   // WRAP, reserved and over-wide beats are flagged; only INCR moves the address
   always_comb begin
      err       = (burst == WRAP) || (burst == 2'b11) || (size > 3'(LG_BYTES));
      next_addr = addr;
      if (burst == INCR) begin
         next_addr = addr + (ADDR_W'(1) << size);
      end
   end
endmodule
`default_nettype wire

// File: rtl/axi_burst_to_iob.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_to_iob
// Description : AXI4 slave that splits bursts into single native accesses
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_to_iob
   import axi_burst_to_iob_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32,
   parameter int ID_W   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   axi_burst_to_iob_if.slave   bus
);
   localparam int LG_BYTES = $clog2(DATA_W/8);

   state_t              state_q, state_d;
   logic                prio_rd_q, prio_rd_d;   // 0: write wins contention
   logic [ID_W-1:0]     id_q, id_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [2:0]          size_q, size_d;
   logic [1:0]          burst_q, burst_d;
   logic                werr_q, werr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                aw_grant, ar_grant, wready;
   logic [ADDR_W-1:0]   next_addr;
   logic                burst_err;
   logic                last_beat;

   assign last_beat = (cnt_q == len_q);

   axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_addr_gen (
      .addr      (addr_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr),
      .err       (burst_err)
   );

   // State register and captured burst context
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         prio_rd_q <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         size_q    <= '0;
         burst_q   <= FIXED;
         werr_q    <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         prio_rd_q <= prio_rd_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         werr_q    <= werr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next-state, arbitration and capture logic
   always_comb begin
      state_d   = state_q;
      prio_rd_d = prio_rd_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      size_d    = size_q;
      burst_d   = burst_q;
      werr_d    = werr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      aw_grant  = 1'b0;
      ar_grant  = 1'b0;
      wready    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            aw_grant = bus.s_axi_awvalid && (!bus.s_axi_arvalid || !prio_rd_q);
            ar_grant = bus.s_axi_arvalid && (!bus.s_axi_awvalid ||  prio_rd_q);
            if (bus.s_axi_awvalid && bus.s_axi_arvalid) begin
               prio_rd_d = !prio_rd_q;
            end
            if (aw_grant) begin
               id_d    = bus.s_axi_awid;
               addr_d  = bus.s_axi_awaddr;
               len_d   = bus.s_axi_awlen;
               size_d  = bus.s_axi_awsize;
               burst_d = bus.s_axi_awburst;
               cnt_d   = '0;
               werr_d  = 1'b0;
               state_d = ST_WR_DATA;
            end else if (ar_grant) begin
               id_d    = bus.s_axi_arid;
               addr_d  = bus.s_axi_araddr;
               len_d   = bus.s_axi_arlen;
               size_d  = bus.s_axi_arsize;
               burst_d = bus.s_axi_arburst;
               cnt_d   = '0;
               state_d = ST_RD_MEM;
            end
         end
         ST_WR_DATA: begin
            wready = 1'b1;
            if (bus.s_axi_wvalid) begin
               wdata_d = bus.s_axi_wdata;
               wstrb_d = bus.s_axi_wstrb;
               if (bus.s_axi_wlast != last_beat) begin
                  werr_d = 1'b1;
               end
               // Unsupported bursts consume beats without touching the memory
               if (!burst_err) begin
                  state_d = ST_WR_MEM;
               end else if (last_beat) begin
                  state_d = ST_WR_RESP;
               end else begin
                  addr_d = next_addr;
                  cnt_d  = cnt_q + 8'd1;
               end
            end
         end
         ST_WR_MEM: begin
            if (bus.ready) begin
               if (last_beat) begin
                  state_d = ST_WR_RESP;
               end else begin
                  addr_d  = next_addr;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = ST_WR_DATA;
               end
            end
         end
         ST_WR_RESP: begin
            if (bus.s_axi_bready) begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_MEM: begin
            // An unsupported burst passes straight through with zero data
            if (burst_err) begin
               rdata_d = '0;
               state_d = ST_RD_DATA;
            end else if (bus.ready) begin
               rdata_d = bus.rdata;
               state_d = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (bus.s_axi_rready) begin
               if (last_beat) begin
                  state_d = ST_IDLE;
               end else begin
                  addr_d  = next_addr;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = burst_err ? ST_RD_DATA : ST_RD_MEM;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.s_axi_awready = aw_grant;
   assign bus.s_axi_arready = ar_grant;
   assign bus.s_axi_wready  = wready;
   assign bus.s_axi_bvalid  = (state_q == ST_WR_RESP);
   assign bus.s_axi_bid     = id_q;
   assign bus.s_axi_bresp   = ((state_q == ST_WR_RESP) && (burst_err || werr_q)) ? SLVERR : OKAY;
   assign bus.s_axi_rvalid  = (state_q == ST_RD_DATA);
   assign bus.s_axi_rid     = id_q;
   assign bus.s_axi_rdata   = rdata_q;
   assign bus.s_axi_rresp   = ((state_q == ST_RD_DATA) && burst_err) ? SLVERR : OKAY;
   assign bus.s_axi_rlast   = (state_q == ST_RD_DATA) && last_beat;
   assign bus.valid         = (state_q == ST_WR_MEM) || ((state_q == ST_RD_MEM) && !burst_err);
   assign bus.addr          = addr_q & ~ADDR_W'((1 << LG_BYTES) - 1);
   assign bus.wdata         = wdata_q;
   assign bus.wstrb         = (state_q == ST_WR_MEM) ? wstrb_q : '0;
endmodule
`default_nettype wire

// File: tb/tb_axi_burst_to_iob.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_to_iob
// Description : Directed plus randomized bench for axi_burst_to_iob
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_to_iob;
   import axi_burst_to_iob_pkg::*;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int ID_W   = 1;
   localparam int TMO    = 400;

   typedef struct {
      logic [ADDR_W-1:0]   a;
      logic [DATA_W-1:0]   d;
      logic [DATA_W/8-1:0] s;
   } acc_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_burst_to_iob_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

   axi_burst_to_iob #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   acc_t nat_log[$];
   acc_t exp_w[$];
   acc_t exp_r[$];
   logic [DATA_W-1:0]   wq_data[$];
   logic [DATA_W/8-1:0] wq_strb[$];
   logic [DATA_W-1:0]   mem [logic [ADDR_W-1:0]];
   int  ready_delay = 0;
   int  nat_wait    = 0;
   int  t_aw, t_ar, lat_w, lat_r;
   bit  model_prio_wr = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Native memory content: unwritten words return an address-derived pattern
   function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
      if (mem.exists(a)) return mem[a];
      return {8'hA5, a};
   endfunction

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a0, input logic [2:0] size,
                                                   input logic [1:0] burst, input int i);
      if (burst == FIXED) return a0;
      return a0 + ADDR_W'(i << size);
   endfunction

   function automatic bit is_err(input logic [2:0] size, input logic [1:0] burst);
      return (burst > 2'b01) || (size > 3'd2);
   endfunction

   // Native memory responder with programmable completion delay
   initial begin
      acc_t snap;
      logic [DATA_W-1:0] w;
      bus.ready = 1'b0;
      bus.rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.ready = 1'b0;
            nat_wait  = 0;
         end else if (bus.ready) begin
            bus.ready = 1'b0;
         end else if (bus.valid) begin
            if (nat_wait == 0) begin
               snap = '{bus.addr, bus.wdata, bus.wstrb};
            end else begin
               chk("nat_addr_stable",  bus.addr,  snap.a);
               chk("nat_wdata_stable", bus.wdata, snap.d);
               chk("nat_wstrb_stable", bus.wstrb, snap.s);
            end
            if (nat_wait >= ready_delay) begin
               nat_log.push_back(snap);
               if (snap.s == '0) begin
                  bus.rdata = mem_rd(snap.a);
               end else begin
                  w = mem_rd(snap.a);
                  for (int b = 0; b < DATA_W/8; b++)
                     if (snap.s[b]) w[8*b +: 8] = snap.d[8*b +: 8];
                  mem[snap.a] = w;
               end
               bus.ready = 1'b1;
               nat_wait  = 0;
            end else begin
               nat_wait++;
            end
         end else if (nat_wait > 0) begin
            chk("nat_valid_held", bus.valid, 1'b1);
            nat_wait = 0;
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_awready"}, bus.s_axi_awready, 1'b0);
      chk({tag, "_arready"}, bus.s_axi_arready, 1'b0);
      chk({tag, "_wready"},  bus.s_axi_wready,  1'b0);
      chk({tag, "_bvalid"},  bus.s_axi_bvalid,  1'b0);
      chk({tag, "_rvalid"},  bus.s_axi_rvalid,  1'b0);
      chk({tag, "_resp"},    {bus.s_axi_bresp, bus.s_axi_rresp}, 4'h0);
      chk({tag, "_rdata"},   bus.s_axi_rdata,   '0);
      chk({tag, "_rlast"},   bus.s_axi_rlast,   1'b0);
      chk({tag, "_ids"},     {bus.s_axi_bid, bus.s_axi_rid}, '0);
      chk({tag, "_valid"},   bus.valid, 1'b0);
      chk({tag, "_native"},  {bus.addr, bus.wdata, bus.wstrb}, '0);
   endtask

   // Compare the native access log against the expected write/read accesses
   task automatic check_native(input string tag, input bit rd_first);
      acc_t e[$];
      if (rd_first) e = {exp_r, exp_w};
      else          e = {exp_w, exp_r};
      chk({tag, "_nat_count"}, nat_log.size(), e.size());
      for (int i = 0; i < e.size() && i < nat_log.size(); i++) begin
         chk({tag, "_nat_addr"}, nat_log[i].a, e[i].a);
         chk({tag, "_nat_wstrb"}, nat_log[i].s, e[i].s);
         if (e[i].s != '0) chk({tag, "_nat_wdata"}, nat_log[i].d, e[i].d);
      end
      nat_log.delete();
      exp_w.delete();
      exp_r.delete();
   endtask

   task automatic axi_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a0, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad, input int bdelay,
                            input string tag);
      bit got;
      bit err  = is_err(size, burst);
      bit lerr = (bad >= 0) && (bad <= int'(len));
      int t_b;
      for (int i = 0; i <= int'(len); i++)
         if (!err) exp_w.push_back('{beat_addr(a0, size, burst, i) & ~ADDR_W'(3), wq_data[i], wq_strb[i]});
      bus.s_axi_awid = id; bus.s_axi_awaddr = a0; bus.s_axi_awlen = len;
      bus.s_axi_awsize = size; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < TMO; t++) begin #1; got = bus.s_axi_awready; tick(); if (got) break; end
      bus.s_axi_awvalid = 1'b0;
      t_aw = cyc;
      chk({tag, "_aw_hs"}, got, 1'b1);
      for (int i = 0; i <= int'(len); i++) begin
         bus.s_axi_wdata = wq_data[i]; bus.s_axi_wstrb = wq_strb[i];
         bus.s_axi_wlast = (i == int'(len)) ^ (i == bad); bus.s_axi_wvalid = 1'b1;
         got = 1'b0;
         for (int t = 0; t < TMO; t++) begin #1; got = bus.s_axi_wready; tick(); if (got) break; end
         bus.s_axi_wvalid = 1'b0;
         chk({tag, "_w_hs"}, got, 1'b1);
      end
      for (int t = 0; t < TMO && !bus.s_axi_bvalid; t++) tick();
      t_b = cyc;
      lat_w = t_b - t_aw;
      chk({tag, "_bvalid"}, bus.s_axi_bvalid, 1'b1);
      repeat (bdelay) tick();
      chk({tag, "_bresp"}, bus.s_axi_bresp, (err || lerr) ? SLVERR : OKAY);
      chk({tag, "_bid"}, bus.s_axi_bid, id);
      bus.s_axi_bready = 1'b1;
      tick();
      bus.s_axi_bready = 1'b0;
   endtask

   task automatic ar_start(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a0, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input string tag);
      bit got;
      bus.s_axi_arid = id; bus.s_axi_araddr = a0; bus.s_axi_arlen = len;
      bus.s_axi_arsize = size; bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < TMO; t++) begin #1; got = bus.s_axi_arready; tick(); if (got) break; end
      bus.s_axi_arvalid = 1'b0;
      t_ar = cyc;
      chk({tag, "_ar_hs"}, got, 1'b1);
   endtask

   task automatic axi_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a0, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int hold, input string tag);
      bit err = is_err(size, burst);
      logic [ADDR_W-1:0] na;
      logic [DATA_W-1:0] sd;
      logic sl;
      ar_start(id, a0, len, size, burst, tag);
      for (int i = 0; i <= int'(len); i++) begin
         na = beat_addr(a0, size, burst, i) & ~ADDR_W'(3);
         if (!err) exp_r.push_back('{na, '0, '0});
         for (int t = 0; t < TMO && !bus.s_axi_rvalid; t++) tick();
         if (i == 0) lat_r = cyc - t_ar;
         chk({tag, "_rvalid"}, bus.s_axi_rvalid, 1'b1);
         sd = bus.s_axi_rdata;
         sl = bus.s_axi_rlast;
         for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_rvalid"}, bus.s_axi_rvalid, 1'b1);
            chk({tag, "_hold_rdata"}, bus.s_axi_rdata, sd);
            chk({tag, "_hold_rlast"}, bus.s_axi_rlast, sl);
         end
         chk({tag, "_rdata"}, bus.s_axi_rdata, err ? '0 : mem_rd(na));
         chk({tag, "_rresp"}, bus.s_axi_rresp, err ? SLVERR : OKAY);
         chk({tag, "_rlast"}, bus.s_axi_rlast, i == int'(len));
         chk({tag, "_rid"}, bus.s_axi_rid, id);
         bus.s_axi_rready = 1'b1;
         tick();
         bus.s_axi_rready = 1'b0;
      end
   endtask

   task automatic fill_wq(input int n);
      wq_data.delete();
      wq_strb.delete();
      for (int i = 0; i < n; i++) begin
         wq_data.push_back($urandom);
         wq_strb.push_back(4'($urandom_range(1, 15)));
      end
   endtask

   initial begin
      bit rd_first;
      bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
      bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b0;
      bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
      bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Single write with minimum latency
      ready_delay = 0;
      wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
      axi_write(1'b1, 24'h000100, 8'd0, 3'd2, INCR, -1, 0, "single_wr");
      chk("single_wr_latency", lat_w, 2);
      check_native("single_wr", 1'b0);

      // INCR read of four words
      axi_read(1'b0, 24'h000200, 8'd3, 3'd2, INCR, 0, "incr_rd");
      chk("incr_rd_latency", lat_r, 1);
      check_native("incr_rd", 1'b0);

      // FIXED write: every beat lands on the same word
      fill_wq(3);
      axi_write(1'b0, 24'h000040, 8'd2, 3'd2, FIXED, -1, 1, "fixed_wr");
      check_native("fixed_wr", 1'b0);

      // Simultaneous AW and AR, twice: priority alternates on contention
      for (int k = 0; k < 2; k++) begin
         rd_first = !model_prio_wr;
         model_prio_wr = !model_prio_wr;
         fill_wq(2);
         fork
            axi_write(1'b1, 24'h000500 + 24'(k * 64), 8'd1, 3'd2, INCR, -1, 0, "cont_wr");
            axi_read(1'b1, 24'h000600 + 24'(k * 64), 8'd1, 3'd2, INCR, 0, "cont_rd");
         join
         chk("cont_grant_order", t_ar < t_aw, rd_first);
         check_native("cont", rd_first);
      end

      // WRAP read: no native traffic, error response with zero data
      axi_read(1'b1, 24'h000700, 8'd1, 3'd2, WRAP, 0, "wrap_rd");
      check_native("wrap_rd", 1'b0);

      // Early wlast: writes still happen, response is SLVERR
      fill_wq(3);
      axi_write(1'b0, 24'h000800, 8'd2, 3'd2, INCR, 0, 0, "wlast_wr");
      check_native("wlast_wr", 1'b0);

      // Backpressure on both sides
      ready_delay = 3;
      axi_read(1'b0, 24'h000900, 8'd1, 3'd2, INCR, 5, "bp_rd");
      check_native("bp_rd", 1'b0);

      // Address wraps past the top of the address space
      ready_delay = 0;
      axi_read(1'b1, 24'hFFFFF8, 8'd3, 3'd2, INCR, 0, "top_rd");
      check_native("top_rd", 1'b0);

      // 256-beat byte-wide read
      axi_read(1'b0, 24'h001000, 8'd255, 3'd0, INCR, 0, "long_rd");
      check_native("long_rd", 1'b0);

      // Reset during beat 2 of an 8-beat read
      ready_delay = 3;
      ar_start(1'b1, 24'h000300, 8'd7, 3'd2, INCR, "rst_rd");
      for (int t = 0; t < TMO && !bus.s_axi_rvalid; t++) tick();
      chk("rst_rd_beat1", bus.s_axi_rvalid, 1'b1);
      bus.s_axi_rready = 1'b1;
      tick();
      bus.s_axi_rready = 1'b0;
      for (int t = 0; t < TMO && !bus.valid; t++) tick();
      chk("rst_rd_beat2_valid", bus.valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      tick();
      tick();
      rst_n = 1'b1;
      model_prio_wr = 1'b1;
      nat_log.delete(); exp_w.delete(); exp_r.delete();
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("post_reset_quiet", {bus.s_axi_rvalid, bus.s_axi_bvalid, bus.valid}, 3'b000);
      end
      ready_delay = 0;
      axi_read(1'b0, 24'h000340, 8'd1, 3'd2, INCR, 0, "post_rst_rd");
      check_native("post_rst_rd", 1'b0);

      // Randomized bursts
      for (int k = 0; k < 40; k++) begin
         logic [ADDR_W-1:0] a0;
         logic [7:0] len;
         logic [2:0] size;
         logic [1:0] burst;
         int bad;
         a0    = ADDR_W'($urandom);
         len   = 8'($urandom_range(0, 7));
         size  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
         burst = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
         ready_delay = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 0) begin
            fill_wq(int'(len) + 1);
            bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(len)) : -1;
            axi_write(ID_W'($urandom), a0, len, size, burst, bad, $urandom_range(0, 2), "rnd_wr");
         end else begin
            axi_read(ID_W'($urandom), a0, len, size, burst, $urandom_range(0, 2), "rnd_rd");
         end
         check_native("rnd", 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
